// File: rtl/svfpga_route_pkg.sv
// Shared types and constants for the tile routing blocks.
package svfpga_route_pkg;

  localparam int SEL_W      = 3;
  localparam int NUM_LE_OUT = 4;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_OPEN = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } cfg_state_t;

  // Selects 0..3 pick an LE output; 4..7 leave the track undriven.
  function automatic logic sel_drives(input sel_t sel);
    return ~sel[SEL_W-1];
  endfunction

endpackage

// File: rtl/leo_route_cfg_shift_chain.sv
// Serial config chain with shadow shift register, bit counter and commit FSM.
// The committed vector only changes in COMMIT, so loading never disturbs the live route.
module cfg_shift_chain
  import svfpga_route_pkg::*;
#(
  parameter int               WIDTH   = 24,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_config_en,
  input  logic             i_config_data_in,
  output logic             o_config_data_out,
  output logic             o_cfg_err,
  output logic [WIDTH-1:0] o_cfg
);

  localparam int               CNT_W    = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

  cfg_state_t       r_state;
  cfg_state_t       w_state_next;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_cfg;
  logic [CNT_W-1:0] r_count;
  logic             r_cfg_err;
  logic             w_shift;
  logic             w_commit;
  logic             w_load_bad;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // COMMIT never shifts, so a config_en rising there simply waits one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_config_en) w_state_next = SHIFT;
      SHIFT:   if (!i_config_en) w_state_next = (r_count == CNT_FULL) ? COMMIT : IDLE;
      COMMIT:  w_state_next = i_config_en ? SHIFT : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_shift    = (r_state == SHIFT) && i_config_en;
    w_commit   = (r_state == COMMIT);
    w_load_bad = (r_state == SHIFT) && !i_config_en && (r_count != CNT_FULL);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_shreg   <= '1;
      r_cfg     <= RST_VAL;
      r_count   <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      if (w_shift) begin
        r_shreg <= {i_config_data_in, r_shreg[WIDTH-1:1]};
        if (r_count != CNT_SAT) r_count <= r_count + 1'b1;
      end
      if (w_load_bad) begin
        r_cfg_err <= 1'b1;
        r_count   <= '0;
      end
      if (w_commit) begin
        r_cfg     <= r_shreg;
        r_cfg_err <= 1'b0;
        r_count   <= '0;
      end
    end
  end

  assign o_config_data_out = r_shreg[0];
  assign o_cfg_err         = r_cfg_err;
  assign o_cfg             = r_cfg;

endmodule

// File: rtl/leo_route.sv
// LE-output to routing-track drive with serially loaded per-track selects.
// Define LEO_REG_OUT_EN to register trk_out/trk_oe (1-cycle latency); otherwise they are combinational.
module leo_route
  import svfpga_route_pkg::*;
#(
  parameter int NUM_TRACKS = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  config_en,
  input  logic                  config_data_in,
  output logic                  config_data_out,
  input  logic [NUM_LE_OUT-1:0] leout,
  output logic [NUM_TRACKS-1:0] trk_out,
  output logic [NUM_TRACKS-1:0] trk_oe,
  output logic                  cfg_err
);

  localparam int CFG_BITS = NUM_TRACKS * SEL_W;

  logic [CFG_BITS-1:0]   w_cfg;
  logic [NUM_TRACKS-1:0] w_trk_out;
  logic [NUM_TRACKS-1:0] w_trk_oe;

  cfg_shift_chain #(
    .WIDTH   (CFG_BITS),
    .RST_VAL ({NUM_TRACKS{SEL_OPEN}})
  ) u_chain (
    .clk               (clk),
    .nrst              (nrst),
    .i_config_en       (config_en),
    .i_config_data_in  (config_data_in),
    .o_config_data_out (config_data_out),
    .o_cfg_err         (cfg_err),
    .o_cfg             (w_cfg)
  );

  generate
    for (genvar gi = 0; gi < NUM_TRACKS; gi++) begin : g_trk
      sel_t w_sel;
      assign w_sel         = w_cfg[gi*SEL_W +: SEL_W];
      assign w_trk_oe[gi]  = en & sel_drives(w_sel);
      assign w_trk_out[gi] = sel_drives(w_sel) & leout[w_sel[1:0]];
    end
  endgenerate

`ifdef LEO_REG_OUT_EN
  logic [NUM_TRACKS-1:0] r_trk_out;
  logic [NUM_TRACKS-1:0] r_trk_oe;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_trk_out <= '0;
      r_trk_oe  <= '0;
    end else begin
      r_trk_out <= w_trk_out;
      r_trk_oe  <= w_trk_oe;
    end
  end

  assign trk_out = r_trk_out;
  assign trk_oe  = r_trk_oe;
`else
  assign trk_out = w_trk_out;
  assign trk_oe  = w_trk_oe;
`endif

endmodule
